word_capture_serializer: RTL and testbench

- Downstream stage of the enable-gated word-capture block.
- Accepts each 16-bit word plus its 4-bit status tag from that block, buffers them in a small FIFO, and drains each word as two bytes (MSB byte first) over a valid/ready byte stream to the next consumer.
- Reports FIFO level and a sticky overflow flag for status readback.

---
 rtl/word_capture_serializer.sv | 143 ++++++++++++++
 tb/tb_word_capture_serializer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_capture_serializer.sv
// word_capture_serializer: buffers tagged 16-bit words in a small FIFO
// and drains each word as two bytes, high byte first, over valid/ready.
module word_capture_serializer #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [15:0]   in_data,
   input  logic [3:0]    in_status,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_byte,
   output logic [3:0]    out_tag,
   output logic          out_last,
   output logic [AW:0]   level,
   output logic          overflow,
   input  logic          clr_overflow
);

   typedef enum logic [1:0] {IDLE, HI, LO} state_e;

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [15:0]   mem_data [DEPTH];
   logic [3:0]    mem_tag  [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          ovf_q, ovf_d;
   state_e        state_q, state_d;
   logic [7:0]    byte_q, byte_d;
   logic [7:0]    lo_q, lo_d;
   logic [3:0]    tag_q, tag_d;
   logic          last_q, last_d;

   logic          full, wr_en, drop, pop, hs;
   logic [15:0]   head_data;
   logic [3:0]    head_tag;

   assign full      = (level_q == FULL);
   assign wr_en     = in_valid & ~full;
   assign drop      = in_valid & full;
   assign hs        = out_valid & out_ready;
   assign head_data = mem_data[rd_ptr_q];
   assign head_tag  = mem_tag[rd_ptr_q];

   assign in_ready  = ~full;
   assign out_valid = (state_q != IDLE);
   assign out_byte  = byte_q;
   assign out_tag   = tag_q;
   assign out_last  = last_q;
   assign level     = level_q;
   assign overflow  = ovf_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data[wr_ptr_q] <= in_data;
         mem_tag[wr_ptr_q]  <= in_status;
      end
   end

   // Full-check uses the pre-pop level, so a write racing a pop is dropped.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      ovf_d    = drop | (ovf_q & ~clr_overflow);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         state_q  <= IDLE;
         byte_q   <= '0;
         lo_q     <= '0;
         tag_q    <= '0;
         last_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         byte_q   <= byte_d;
         lo_q     <= lo_d;
         tag_q    <= tag_d;
         last_q   <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (level_q != '0) begin
               pop     = 1'b1;
               state_d = HI;
            end
         end
         HI: begin
            if (hs) state_d = LO;
         end
         LO: begin
            if (hs) begin
               if (level_q != '0) begin
                  pop     = 1'b1;
                  state_d = HI;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      byte_d = byte_q;
      lo_d   = lo_q;
      tag_d  = tag_q;
      last_d = last_q;
      if (pop) begin
         byte_d = head_data[15:8];
         lo_d   = head_data[7:0];
         tag_d  = head_tag;
         last_d = 1'b0;
      end else if (hs && state_q == HI) begin
         byte_d = lo_q;
         last_d = 1'b1;
      end else if (hs && state_q == LO) begin
         last_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_word_capture_serializer.sv
// tb_word_capture_serializer: directed vector table plus hand sequences
// for overflow, set/clear collision, wrap-around and async reset.
module tb_word_capture_serializer;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [15:0]   in_data;
   logic [3:0]    in_status;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_byte;
   logic [3:0]    out_tag;
   logic          out_last;
   logic [AW:0]   level;
   logic          overflow;
   logic          clr_overflow;

   word_capture_serializer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_status    (in_status),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_byte     (out_byte),
      .out_tag      (out_tag),
      .out_last     (out_last),
      .level        (level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        iv;
      logic [15:0] d;
      logic [3:0]  st;
      logic        rdy;
      logic        ev;
      logic [7:0]  eb;
      logic [3:0]  et;
      logic        el;
      logic [3:0]  elv;
   } vec_t;

   typedef struct packed {
      logic [7:0] b;
      logic [3:0] t;
      logic       l;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   logic mon_en = 1'b0;
   vec_t vecs [$];
   exp_t exp_q [$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req,
                  $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic addv(input logic iv, input logic [15:0] d,
                       input logic [3:0] st, input logic rdy,
                       input logic ev, input logic [7:0] eb,
                       input logic [3:0] et, input logic el,
                       input logic [3:0] elv);
      vec_t v;
      v = '{iv, d, st, rdy, ev, eb, et, el, elv};
      vecs.push_back(v);
   endtask

   task automatic push_word(input logic [15:0] d, input logic [3:0] t);
      exp_t e;
      e = '{d[15:8], t, 1'b0};
      exp_q.push_back(e);
      e = '{d[7:0], t, 1'b1};
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int limit);
      int k;
      k = 0;
      while (k < limit && (exp_q.size() != 0 || out_valid)) begin
         tick();
         k++;
      end
      chk("drain_done", 32'(exp_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (mon_en && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %0h expected none",
                     out_byte);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stream_byte", 32'(out_byte), 32'(e.b));
            chk("stream_tag", 32'(out_tag), 32'(e.t));
            chk("stream_last", 32'(out_last), 32'(e.l));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int maxlvl;

      reset        = 1'b0;
      in_valid     = 1'b0;
      in_data      = '0;
      in_status    = '0;
      out_ready    = 1'b0;
      clr_overflow = 1'b0;
      repeat (2) tick();

      chk("rst_level", 32'(level), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_byte", 32'(out_byte), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      reset = 1'b1;
      tick();

      // single word, then two words under toggling backpressure
      addv(1, 16'hA500, 4'h3, 1, 0, 8'h00, 4'h0, 0, 4'd1);
      addv(0, 16'h0000, 4'h0, 1, 1, 8'hA5, 4'h3, 0, 4'd0);
      addv(0, 16'h0000, 4'h0, 1, 1, 8'h00, 4'h3, 1, 4'd0);
      addv(0, 16'h0000, 4'h0, 1, 0, 8'h00, 4'h0, 0, 4'd0);
      addv(1, 16'h1234, 4'h1, 0, 0, 8'h00, 4'h0, 0, 4'd1);
      addv(1, 16'h5678, 4'h2, 1, 1, 8'h12, 4'h1, 0, 4'd1);
      addv(0, 16'h0000, 4'h0, 0, 1, 8'h12, 4'h1, 0, 4'd1);
      addv(0, 16'h0000, 4'h0, 1, 1, 8'h34, 4'h1, 1, 4'd1);
      addv(0, 16'h0000, 4'h0, 0, 1, 8'h34, 4'h1, 1, 4'd1);
      addv(0, 16'h0000, 4'h0, 1, 1, 8'h56, 4'h2, 0, 4'd0);
      addv(0, 16'h0000, 4'h0, 0, 1, 8'h56, 4'h2, 0, 4'd0);
      addv(0, 16'h0000, 4'h0, 1, 1, 8'h78, 4'h2, 1, 4'd0);
      addv(0, 16'h0000, 4'h0, 0, 1, 8'h78, 4'h2, 1, 4'd0);
      addv(0, 16'h0000, 4'h0, 1, 0, 8'h00, 4'h0, 0, 4'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         in_valid  = vecs[i].iv;
         in_data   = vecs[i].d;
         in_status = vecs[i].st;
         out_ready = vecs[i].rdy;
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(out_valid),
             32'(vecs[i].ev));
         chk($sformatf("vec%0d_last", i), 32'(out_last),
             32'(vecs[i].el));
         chk($sformatf("vec%0d_level", i), 32'(level),
             32'(vecs[i].elv));
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d_byte", i), 32'(out_byte),
                32'(vecs[i].eb));
            chk($sformatf("vec%0d_tag", i), 32'(out_tag),
                32'(vecs[i].et));
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // overflow: one word sits in the output stage, DEPTH in the FIFO
      mon_en = 1'b1;
      for (int i = 0; i <= DEPTH; i++) push_word(16'(i), 4'(i));
      for (int i = 0; i < DEPTH + 2; i++) begin
         in_valid  = 1'b1;
         in_data   = 16'(i);
         in_status = 4'(i);
         tick();
      end
      in_valid = 1'b0;
      chk("ovf_level", 32'(level), 32'(DEPTH));
      chk("ovf_in_ready", 32'(in_ready), 32'd0);
      chk("ovf_flag", 32'(overflow), 32'd1);
      out_ready = 1'b1;
      wait_drain(100);
      chk("ovf_drained_level", 32'(level), 32'd0);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);
      mon_en = 1'b0;

      // set/clear collision and write-while-full racing a pop
      out_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         in_valid = 1'b1;
         in_data  = 16'h4000 + 16'(i);
         tick();
      end
      in_valid = 1'b0;
      chk("col_full_level", 32'(level), 32'(DEPTH));
      chk("col_pre_ovf", 32'(overflow), 32'd0);
      in_valid     = 1'b1;
      clr_overflow = 1'b1;
      tick();
      chk("col_set_wins", 32'(overflow), 32'd1);
      chk("col_level_kept", 32'(level), 32'(DEPTH));
      in_valid = 1'b0;
      tick();
      clr_overflow = 1'b0;
      chk("col_clear", 32'(overflow), 32'd0);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("race_level", 32'(level), 32'(DEPTH - 1));
      chk("race_drop", 32'(overflow), 32'd1);
      for (int k = 0; k < 100 && (level != 0 || out_valid); k++) tick();
      chk("race_drained", 32'(level), 32'd0);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;

      // wrap-around: 3*DEPTH words, one every other cycle
      mon_en = 1'b1;
      maxlvl = 0;
      for (int c = 0; c < 6 * DEPTH; c++) begin
         in_valid = (c % 2 == 0);
         if (in_valid) begin
            in_data   = {8'(c / 2), ~8'(c / 2)};
            in_status = 4'(c / 2);
            push_word(in_data, in_status);
         end
         tick();
         if (int'(level) > maxlvl) maxlvl = int'(level);
      end
      in_valid = 1'b0;
      wait_drain(100);
      chk("wrap_max_level_ok", 32'(maxlvl <= 2), 32'd1);
      chk("wrap_no_overflow", 32'(overflow), 32'd0);

      // async reset while in LO with 3 words queued
      mon_en    = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 16'h7700 + 16'(i);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pre_rst_last", 32'(out_last), 32'd1);
      chk("pre_rst_level", 32'(level), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_out_last", 32'(out_last), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      tick();
      mon_en = 1'b1;
      push_word(16'hBEEF, 4'h5);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'hBEEF;
      in_status = 4'h5;
      tick();
      in_valid = 1'b0;
      wait_drain(50);
      chk("post_rst_level", 32'(level), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
